// File: rtl/pipe_pkg.sv
// Shared widths and payload packing for the inter-stage pipeline registers.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned IF_ID_W = 64;
    localparam int unsigned OCC_W   = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    // IF/ID payload: PC in the upper half, instruction in the lower half.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    function automatic logic [IF_ID_W-1:0] pack_if_id(
        input logic [PC_W-1:0]    pc,
        input logic [INSTR_W-1:0] instr
    );
        if_id_t p;
        p.pc    = pc;
        p.instr = instr;
        return IF_ID_W'(p);
    endfunction

    function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] raw);
        return if_id_t'(raw);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit; flush beats load beats clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = IF_ID_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= FLUSH_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            q     <= FLUSH_VAL;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            // Data is left in place so out_data holds the last popped value.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Valid/ready pipeline register with optional skid slot and synchronous bubble flush.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = IF_ID_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic              main_load;
    logic              main_clear;
    logic              accept;
    logic              pop;

    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    pipe_slot #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    if (SKID) begin : g_skid
        logic              skid_valid;
        logic [DATA_W-1:0] skid_q;
        logic              skid_load;
        logic              skid_clear;
        logic              main_nxt;
        logic              skid_nxt;
        logic              ready_q;
        logic [OCC_W-1:0]  occ_q;

        pipe_slot #(
            .DATA_W    (DATA_W),
            .FLUSH_VAL (FLUSH_VAL)
        ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_data),
            .valid (skid_valid),
            .q     (skid_q)
        );

        // Skid full: only refill main from skid. Otherwise main takes new data
        // when it is free or draining, and skid catches data while main stalls.
        always_comb begin
            main_load  = 1'b0;
            main_clear = 1'b0;
            main_d     = in_data;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            if (skid_valid) begin
                if (pop) begin
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    skid_clear = 1'b1;
                end
            end else if (!main_valid || pop) begin
                main_load  = accept;
                main_clear = pop & ~accept;
            end else begin
                skid_load = accept;
            end
            main_nxt = main_load | (main_valid & ~main_clear);
            skid_nxt = skid_load | (skid_valid & ~skid_clear);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ready_q <= 1'b1;
                occ_q   <= '0;
            end else if (flush) begin
                ready_q <= 1'b1;
                occ_q   <= '0;
            end else begin
                ready_q <= ~skid_nxt;
                occ_q   <= OCC_W'(main_nxt) + OCC_W'(skid_nxt);
            end
        end

        assign in_ready  = ready_q;
        assign occupancy = occ_q;
    end else begin : g_noskid
        always_comb begin
            main_d     = in_data;
            main_load  = accept;
            main_clear = pop & ~accept;
        end

        assign in_ready  = ~main_valid | out_ready;
        assign occupancy = OCC_W'(main_valid);
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg with and without the skid slot.
module tb_elastic_pipe_reg;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         in_ready1, out_valid1, in_ready0, out_valid0;
    logic [W-1:0] out_data1, out_data0;
    logic [1:0]   occ1, occ0;

    int vectors = 0;
    int miscompares = 0;

    // Reference: FIFO contents of each stage plus the last value shown on out_data.
    logic [W-1:0] m1[$];
    logic [W-1:0] m0[$];
    logic [W-1:0] last1 = '0;
    logic [W-1:0] last0 = '0;

    logic [67:0] obs1, obs0;
    assign obs1 = {out_valid1, out_data1, in_ready1, occ1};
    assign obs0 = {out_valid0, out_data0, in_ready0, occ0};

    always #5 clk = ~clk;

    elastic_pipe_reg #(.DATA_W(W), .FLUSH_VAL('0), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    elastic_pipe_reg #(.DATA_W(W), .FLUSH_VAL('0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    function automatic logic [67:0] exp1();
        logic v;
        v = (m1.size() > 0);
        return {v, (v ? m1[0] : last1), (m1.size() < 2), 2'(m1.size())};
    endfunction

    function automatic logic [67:0] exp0();
        logic v;
        v = (m0.size() > 0);
        return {v, (v ? m0[0] : last0), (m0.size() == 0) || out_ready, 2'(m0.size())};
    endfunction

    task automatic model_reset();
        m1.delete();
        m0.delete();
        last1 = '0;
        last0 = '0;
    endtask

    // Advance one clock and apply the handshake rules to the reference queues.
    task automatic tick();
        bit acc1, pop1, acc0, pop0, fl;
        logic [W-1:0] dv;
        acc1 = in_valid && (m1.size() < 2);
        pop1 = (m1.size() > 0) && out_ready;
        acc0 = in_valid && ((m0.size() == 0) || out_ready);
        pop0 = (m0.size() > 0) && out_ready;
        dv   = in_data;
        fl   = flush;
        @(posedge clk);
        if (rst || fl) begin
            model_reset();
        end else begin
            if (pop1) last1 = m1.pop_front();
            if (acc1) m1.push_back(dv);
            if (pop0) last0 = m0.pop_front();
            if (acc0) m0.push_back(dv);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        if (out_valid1 !== 1'b0 || out_data1 !== '0 || in_ready1 !== 1'b1 || occ1 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_skid1 got %h exp %h", obs1, {1'b0, 64'h0, 1'b1, 2'd0});
        end
        vectors++;
        if (out_valid0 !== 1'b0 || out_data0 !== '0 || in_ready0 !== 1'b1 || occ0 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_skid0 got %h exp %h", obs0, {1'b0, 64'h0, 1'b1, 2'd0});
        end
        vectors++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = (i <= 4);
            in_data  = W'(i);
            #1;
            if (obs1 !== exp1()) begin
                miscompares++;
                $display("FAIL stream_skid1 cyc %0d got %h exp %h", i, obs1, exp1());
            end
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL stream_skid0 cyc %0d got %h exp %h", i, obs0, exp0());
            end
            vectors++;
            if (i >= 2 && i <= 5 && (out_data1 !== W'(i - 1) || occ1 !== 2'd1)) begin
                miscompares++;
                $display("FAIL stream_order cyc %0d got %h/%0d exp %h/1", i, out_data1, occ1, W'(i - 1));
            end
            vectors++;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] seq[3];
        bit held;
        int idx;
        seq[0] = 64'hA; seq[1] = 64'hB; seq[2] = 64'hC;
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? seq[idx] : '0;
            #1;
            if (obs1 !== exp1()) begin
                miscompares++;
                $display("FAIL stall_skid1 cyc %0d got %h exp %h", c, obs1, exp1());
            end
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL stall_skid0 cyc %0d got %h exp %h", c, obs0, exp0());
            end
            vectors++;
            if (c == 2 && (in_ready1 !== 1'b0 || occ1 !== 2'd2 || out_data1 !== 64'hA)) begin
                miscompares++;
                $display("FAIL stall_full got rdy %b occ %0d data %h exp rdy 0 occ 2 data a", in_ready1, occ1, out_data1);
            end
            vectors++;
            held = in_valid && !in_ready1;
            tick();
            if (!held && idx < 3) idx++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c <= 2);
            in_data  = (c == 0) ? 64'hA : (c == 1) ? 64'hB : 64'hC;
            flush    = (c == 2);
            out_ready = (c >= 4);
            #1;
            if (obs1 !== exp1()) begin
                miscompares++;
                $display("FAIL flush_skid1 cyc %0d got %h exp %h", c, obs1, exp1());
            end
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL flush_skid0 cyc %0d got %h exp %h", c, obs0, exp0());
            end
            vectors++;
            if (c == 3 && (out_valid1 !== 1'b0 || out_data1 !== '0 || occ1 !== 2'd0 || in_ready1 !== 1'b1)) begin
                miscompares++;
                $display("FAIL flush_bubble got %h exp %h", obs1, {1'b0, 64'h0, 1'b1, 2'd0});
            end
            vectors++;
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = {$urandom, $urandom};
            #1;
            if (obs1 !== exp1()) begin
                miscompares++;
                $display("FAIL random_skid1 cyc %0d got %h exp %h", c, obs1, exp1());
            end
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL random_skid0 cyc %0d got %h exp %h", c, obs0, exp0());
            end
            vectors++;
            if (occ1 > 2'd2 || occ0 > 2'd1) begin
                miscompares++;
                $display("FAIL random_occ cyc %0d got %0d/%0d exp <=2/<=1", c, occ1, occ0);
            end
            vectors++;
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        #1;
        if (occ1 !== 2'd2 || obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL rststall_full got %h exp %h", obs1, exp1());
        end
        vectors++;
        #1 rst = 1'b1;
        #1 model_reset();
        if (obs1 !== exp1() || obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL rststall_clear got %h %h exp %h %h", obs1, obs0, exp1(), exp0());
        end
        vectors++;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_data  = W'(64'h100 + i);
            #1;
            if (obs1 !== exp1()) begin
                miscompares++;
                $display("FAIL rststall_stream_skid1 cyc %0d got %h exp %h", i, obs1, exp1());
            end
            vectors++;
            if (obs0 !== exp0()) begin
                miscompares++;
                $display("FAIL rststall_stream_skid0 cyc %0d got %h exp %h", i, obs0, exp0());
            end
            vectors++;
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_random();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
